// File: rtl/sdm_cic_decim.sv
// Multi-channel CIC decimator for 1-bit sigma-delta bitstreams with a
// valid/ready result port, warm-up suppression and sticky overrun flag.
module sdm_cic_decim #(
    parameter int unsigned CH         = 2,
    parameter int unsigned ORDER      = 4,
    parameter int unsigned DECIM_LOG2 = 6,
    parameter int unsigned OUT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sync_clr,
    input  logic                  valid_in,
    input  logic [CH-1:0]         din,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [CH*OUT_W-1:0]   dout,
    output logic                  overrun
);

    localparam int unsigned ACC_W  = ORDER * DECIM_LOG2 + 1;
    // One guard bit so the positive full-scale result +2^(ACC_W-1) is representable
    localparam int unsigned INT_W  = ACC_W + 1;
    localparam int unsigned SHIFT  = ACC_W - OUT_W;
    localparam int unsigned WARM_W = $clog2(ORDER + 1);

    localparam logic [DECIM_LOG2-1:0]   CNT_LAST  = '1;
    localparam logic [WARM_W-1:0]       WARM_DONE = WARM_W'(ORDER);
    localparam logic [INT_W-1:0]        SAMP_POS  = INT_W'(1);
    localparam logic [INT_W-1:0]        SAMP_NEG  = '1;
    localparam logic signed [INT_W-1:0] SAT_MAX   = INT_W'((64'd1 << (OUT_W - 1)) - 64'd1);
    localparam logic signed [INT_W-1:0] SAT_MIN   = ~SAT_MAX;

    logic [INT_W-1:0]      r_int [CH][ORDER];
    logic [INT_W-1:0]      r_cmb [CH][ORDER+1];
    logic [INT_W-1:0]      r_dly [CH][ORDER];
    logic [ORDER:0]        r_cv;
    logic [ORDER:0]        r_ct;
    logic [DECIM_LOG2-1:0] r_dcnt;
    logic [WARM_W-1:0]     r_warm;

    logic                  w_cap;
    logic signed [INT_W-1:0] w_sh;
    logic [CH*OUT_W-1:0]   w_res;

    assign w_cap = valid_in && (r_dcnt == CNT_LAST);

    // Integrator cascade and decimation counter, advancing only on accepted samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dcnt <= '0;
            for (int unsigned c = 0; c < CH; c++)
                for (int unsigned k = 0; k < ORDER; k++)
                    r_int[c][k] <= '0;
        end else if (sync_clr) begin
            r_dcnt <= '0;
            for (int unsigned c = 0; c < CH; c++)
                for (int unsigned k = 0; k < ORDER; k++)
                    r_int[c][k] <= '0;
        end else if (valid_in) begin
            r_dcnt <= r_dcnt + 1'b1;
            for (int unsigned c = 0; c < CH; c++) begin
                r_int[c][0] <= r_int[c][0] + (din[c] ? SAMP_POS : SAMP_NEG);
                for (int unsigned k = 1; k < ORDER; k++)
                    r_int[c][k] <= r_int[c][k] + r_int[c][k-1];
            end
        end
    end

    // Comb pipeline; r_cv marks live data per stage, r_ct marks results past warm-up
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cv   <= '0;
            r_ct   <= '0;
            r_warm <= '0;
            for (int unsigned c = 0; c < CH; c++) begin
                for (int unsigned j = 0; j <= ORDER; j++) r_cmb[c][j] <= '0;
                for (int unsigned j = 0; j < ORDER; j++)  r_dly[c][j] <= '0;
            end
        end else if (sync_clr) begin
            r_cv   <= '0;
            r_ct   <= '0;
            r_warm <= '0;
            for (int unsigned c = 0; c < CH; c++) begin
                for (int unsigned j = 0; j <= ORDER; j++) r_cmb[c][j] <= '0;
                for (int unsigned j = 0; j < ORDER; j++)  r_dly[c][j] <= '0;
            end
        end else begin
            r_cv[0] <= w_cap;
            r_ct[0] <= w_cap && (r_warm == WARM_DONE);
            if (w_cap) begin
                if (r_warm != WARM_DONE) r_warm <= r_warm + 1'b1;
                for (int unsigned c = 0; c < CH; c++)
                    r_cmb[c][0] <= r_int[c][ORDER-1];
            end
            for (int unsigned j = 1; j <= ORDER; j++) begin
                r_cv[j] <= r_cv[j-1];
                r_ct[j] <= r_ct[j-1];
                if (r_cv[j-1]) begin
                    for (int unsigned c = 0; c < CH; c++) begin
                        r_cmb[c][j]   <= r_cmb[c][j-1] - r_dly[c][j-1];
                        r_dly[c][j-1] <= r_cmb[c][j-1];
                    end
                end
            end
        end
    end

    // Scale to OUT_W; only +full-scale can exceed the range
    always_comb begin
        w_res = '0;
        w_sh  = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            w_sh = $signed(r_cmb[c][ORDER]) >>> SHIFT;
            if (w_sh > SAT_MAX)
                w_res[c*OUT_W +: OUT_W] = OUT_W'(SAT_MAX);
            else if (w_sh < SAT_MIN)
                w_res[c*OUT_W +: OUT_W] = OUT_W'(SAT_MIN);
            else
                w_res[c*OUT_W +: OUT_W] = OUT_W'(w_sh);
        end
    end

    // Output register: freshest result wins, overrun is sticky until cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_valid <= 1'b0;
            dout       <= '0;
            overrun    <= 1'b0;
        end else if (sync_clr) begin
            dout_valid <= 1'b0;
            dout       <= '0;
            overrun    <= 1'b0;
        end else if (r_cv[ORDER] && r_ct[ORDER]) begin
            dout       <= w_res;
            dout_valid <= 1'b1;
            if (dout_valid && !dout_ready) overrun <= 1'b1;
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sdm_cic_decim.sv
// Scoreboard bench for sdm_cic_decim at default parameters (CH=2, N=4, D=64, OUT_W=16).
module tb_sdm_cic_decim;

    localparam int unsigned D     = 64;
    localparam int unsigned ORDER = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        sync_clr;
    logic        valid_in;
    logic [1:0]  din;
    logic        dout_valid;
    logic        dout_ready;
    logic [31:0] dout;
    logic        overrun;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int unsigned t;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];

    sdm_cic_decim dut (
        .clk        (clk),
        .rst        (rst),
        .sync_clr   (sync_clr),
        .valid_in   (valid_in),
        .din        (din),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout       (dout),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bitstream pattern p at accepted-sample index n (bit c = channel c)
    function automatic logic [1:0] pat(input int p, input int unsigned n);
        logic [1:0] r;
        case (p)
            0:       r = 2'b11;
            1:       r = 2'b00;
            default: begin
                r[0] = (n % 8 == 0);
                r[1] = (n % 2 == 0);
            end
        endcase
        return r;
    endfunction

    // Settled outputs: +FS saturates, -FS exact, ch0 mean -3/4 -> -24576, ch1 mean 0
    function automatic logic [31:0] pat_exp(input int p);
        case (p)
            0:       return 32'h7fff_7fff;
            1:       return 32'h8000_8000;
            default: return 32'h0000_a000;
        endcase
    endfunction

    task automatic step(input logic v, input logic [1:0] d);
        @(posedge clk);
        #1;
        valid_in = v;
        din      = d;
    endtask

    task automatic monitor();
        exp_t e;
        @(negedge clk);
        if (dout_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output cyc=%0d got dout=%h required no dout_valid", cyc, dout);
            end else begin
                e = sb.pop_front();
                if (dout !== e.v) begin
                    errors++;
                    $display("FAIL out_value cyc=%0d got=%h required=%h", cyc, dout, e.v);
                end
                checks++;
                if (cyc !== e.t) begin
                    errors++;
                    $display("FAIL out_timing got cyc=%0d required cyc=%0d", cyc, e.t);
                end
            end
        end
    endtask

    // Stream nsamp accepted samples of pattern p; idle cycles carry inverted (garbage) data
    task automatic run_stream(input int p, input int unsigned nsamp, input bit toggle, input bit clr);
        int unsigned n    = 0;
        int unsigned caps = 0;
        int unsigned i    = 0;
        logic        v;
        dout_ready = 1'b1;
        if (clr) begin
            step(1'b1, ~pat(p, 0));
            sync_clr = 1'b1;
        end
        while (n < nsamp) begin
            v = toggle ? (i % 2 == 0) : 1'b1;
            step(v, v ? pat(p, n) : ~pat(p, n));
            sync_clr = 1'b0;
            i++;
            if (v) begin
                n++;
                if (n % D == 0) begin
                    caps++;
                    if (caps > ORDER) sb.push_back('{cyc + 6, pat_exp(p)});
                end
            end
            monitor();
        end
        repeat (8) begin
            step(1'b0, 2'b00);
            monitor();
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_outputs got %0d pending required 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; sync_clr = 1'b0; valid_in = 1'b0; din = 2'b00; dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({dout_valid, overrun, dout} !== 34'd0) begin
            errors++;
            $display("FAIL reset_state got valid=%b ovr=%b dout=%h required all 0", dout_valid, overrun, dout);
        end
        step(1'b0, 2'b00);
        rst = 1'b0;
    endtask

    task automatic test_full_scale();     run_stream(0, 10*D, 1'b0, 1'b1); endtask
    task automatic test_neg_full_scale(); run_stream(1, 10*D, 1'b0, 1'b1); endtask
    task automatic test_pattern();        run_stream(2, 10*D, 1'b0, 1'b1); endtask
    task automatic test_valid_toggle();   run_stream(0, 10*D, 1'b1, 1'b1); endtask

    task automatic test_overrun();
        step(1'b0, 2'b00);
        sync_clr   = 1'b1;
        dout_ready = 1'b0;
        for (int m = 1; m <= 646; m++) begin
            step(1'b1, (m <= 320) ? 2'b11 : 2'b00);
            sync_clr = 1'b0;
            if (m == 325) begin
                checks++;
                if (dout_valid !== 1'b0) begin
                    errors++; $display("FAIL ovr_early got valid=%b required 0", dout_valid);
                end
            end
            if (m == 326 || m == 389) begin
                checks++;
                if ({dout_valid, overrun, dout} !== {1'b1, 1'b0, 32'h7fff_7fff}) begin
                    errors++;
                    $display("FAIL ovr_held m=%0d got valid=%b ovr=%b dout=%h required 1/0/7fff7fff",
                             m, dout_valid, overrun, dout);
                end
            end
            if (m == 390) begin
                checks++;
                if ({dout_valid, overrun} !== 2'b11) begin
                    errors++; $display("FAIL ovr_set got valid=%b ovr=%b required 1/1", dout_valid, overrun);
                end
            end
        end
        checks++;
        if ({dout_valid, overrun, dout} !== {1'b1, 1'b1, 32'h8000_8000}) begin
            errors++;
            $display("FAIL ovr_fresh got valid=%b ovr=%b dout=%h required 1/1/80008000", dout_valid, overrun, dout);
        end
        step(1'b0, 2'b00);
        dout_ready = 1'b1;
        step(1'b0, 2'b00);
        checks++;
        if ({dout_valid, overrun} !== 2'b01) begin
            errors++; $display("FAIL ovr_sticky got valid=%b ovr=%b required 0/1", dout_valid, overrun);
        end
        sync_clr = 1'b1;
        step(1'b0, 2'b00);
        sync_clr = 1'b0;
        checks++;
        if ({dout_valid, overrun, dout} !== 34'd0) begin
            errors++;
            $display("FAIL ovr_clear got valid=%b ovr=%b dout=%h required all 0", dout_valid, overrun, dout);
        end
        run_stream(0, 6*D, 1'b0, 1'b0);
    endtask

    task automatic test_async_rst();
        step(1'b0, 2'b00);
        sync_clr   = 1'b1;
        dout_ready = 1'b0;
        for (int m = 1; m <= 5*D + 30; m++) begin
            step(1'b1, 2'b11);
            sync_clr = 1'b0;
        end
        checks++;
        if (dout_valid !== 1'b1) begin
            errors++; $display("FAIL rst_pending got valid=%b required 1", dout_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({dout_valid, overrun, dout} !== 34'd0) begin
            errors++;
            $display("FAIL rst_async got valid=%b ovr=%b dout=%h required all 0", dout_valid, overrun, dout);
        end
        step(1'b0, 2'b00);
        step(1'b0, 2'b00);
        rst = 1'b0;
        run_stream(0, 6*D, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_full_scale();
        test_neg_full_scale();
        test_pattern();
        test_valid_toggle();
        test_overrun();
        test_async_rst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
